// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard controller bundle: pipeline status in, stall/flush controls
// and status counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      i_id_inst;
  logic [4:0]       i_ex_rd;
  logic             i_ex_regwen;
  logic             i_ex_is_load;
  logic             i_ex_redirect;
  logic             i_mem_req;
  logic             i_mem_ready;
  logic             o_pc_stall;
  logic             o_ifid_stall;
  logic             o_ifid_flush;
  logic             o_idex_stall;
  logic             o_idex_flush;
  logic             o_exmem_stall;
  logic             o_memwb_flush;
  logic             o_state;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;
  logic             o_timeout;

  modport master (
    output i_id_inst, i_ex_rd, i_ex_regwen, i_ex_is_load, i_ex_redirect,
           i_mem_req, i_mem_ready,
    input  o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush,
           o_exmem_stall, o_memwb_flush, o_state, o_stall_cnt, o_flush_cnt,
           o_timeout
  );

  modport slave (
    input  i_id_inst, i_ex_rd, i_ex_regwen, i_ex_is_load, i_ex_redirect,
           i_mem_req, i_mem_ready,
    output o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush,
           o_exmem_stall, o_memwb_flush, o_state, o_stall_cnt, o_flush_cnt,
           o_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage forwarding core: load-use bubbles,
// redirect flushes, data-memory freezes, perf counters and a wait watchdog.
//
// state    | meaning
// RUN      | pipeline advancing (possibly with a bubble or flush)
// MEM_WAIT | data memory access outstanding, whole pipeline frozen
module hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic          i_clk,
  input  logic          i_reset,
  hazard_ctrl_if.slave  bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t           state;
  logic [WD_W-1:0]  wait_cnt;
  logic             timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       use_rs1;
  logic       use_rs2;
  logic       load_use;
  logic       mem_stall;
  logic       unused_inst;

  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic exmem_stall, memwb_flush;

  assign opcode      = bus.i_id_inst[6:0];
  assign rs1         = bus.i_id_inst[19:15];
  assign rs2         = bus.i_id_inst[24:20];
  assign unused_inst = ^{bus.i_id_inst[31:25], bus.i_id_inst[14:7]};

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign load_use = bus.i_ex_is_load & bus.i_ex_regwen & (bus.i_ex_rd != 5'd0) &
                    ((use_rs1 & (rs1 == bus.i_ex_rd)) |
                     (use_rs2 & (rs2 == bus.i_ex_rd)));
  assign mem_stall = bus.i_mem_req & ~bus.i_mem_ready;

  // A redirect held across a memory freeze only fires once the freeze drops.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    memwb_flush = 1'b0;
    if (i_reset) begin
      if (mem_stall) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
      end else if (bus.i_ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN:      if (mem_stall) state <= MEM_WAIT;
        MEM_WAIT: if (!mem_stall) state <= RUN;
        default:  state <= RUN;
      endcase

      if (state == MEM_WAIT) begin
        if (!mem_stall) begin
          wait_cnt <= '0;
        end else if (wait_cnt != WD_LIMIT) begin
          wait_cnt <= wait_cnt + WD_W'(1);
          if (wait_cnt == WD_LIMIT - WD_W'(1)) timeout <= 1'b1;
        end
      end

      if (pc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.o_pc_stall    = pc_stall;
  assign bus.o_ifid_stall  = ifid_stall;
  assign bus.o_ifid_flush  = ifid_flush;
  assign bus.o_idex_stall  = idex_stall;
  assign bus.o_idex_flush  = idex_flush;
  assign bus.o_exmem_stall = exmem_stall;
  assign bus.o_memwb_flush = memwb_flush;
  assign bus.o_state       = (state == MEM_WAIT);
  assign bus.o_stall_cnt   = stall_cnt;
  assign bus.o_flush_cnt   = flush_cnt;
  assign bus.o_timeout     = timeout;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, hand sequences for multi-cycle corners,
// then random traffic against a behavioural model.
module tb_hazard_ctrl;
  localparam int CW  = 4;
  localparam int TO  = 4;
  localparam int SAT = (1 << CW) - 1;

  localparam logic [31:0] ADD_X6_X5_X7 = 32'h0072_8333;
  localparam logic [31:0] LUI_X5       = 32'h0002_82B7;
  localparam logic [31:0] ADDI_X6_X5   = 32'h0012_8313;
  localparam logic [31:0] SW_X7_X5     = 32'h0072_A023;
  localparam logic [31:0] JALR_X5      = 32'h0002_8067;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_MEM  = 7'b1101011;
  localparam logic [6:0] C_RED  = 7'b0010100;
  localparam logic [6:0] C_LU   = 7'b1100100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hif ();
  hazard_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (hif.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  int m_stall, m_flush, m_run;
  bit m_wait, m_to;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        regwen, load, redir, req, ready;
    logic [6:0]  exp;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctrl_act();
    return {hif.o_pc_stall, hif.o_ifid_stall, hif.o_ifid_flush, hif.o_idex_stall,
            hif.o_idex_flush, hif.o_exmem_stall, hif.o_memwb_flush};
  endfunction

  // Expected control word from the hazard rules, priority mem > redirect > load-use.
  function automatic logic [6:0] ctrl_ref();
    logic [31:0] inst;
    bit r1, r2, hit, lu;
    inst = hif.i_id_inst;
    r1 = inst[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011,
                           7'b0010011, 7'b0000011, 7'b1100111};
    r2 = inst[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    hit = (r1 && inst[19:15] == hif.i_ex_rd) || (r2 && inst[24:20] == hif.i_ex_rd);
    lu = hif.i_ex_is_load && hif.i_ex_regwen && hif.i_ex_rd != 0 && hit;
    if (hif.i_mem_req && !hif.i_mem_ready) return C_MEM;
    if (hif.i_ex_redirect) return C_RED;
    if (lu) return C_LU;
    return C_NONE;
  endfunction

  task automatic set_in(input logic [31:0] inst, input logic [4:0] rd, input logic regwen,
                        input logic load, input logic redir, input logic req, input logic ready);
    hif.i_id_inst     = inst;
    hif.i_ex_rd       = rd;
    hif.i_ex_regwen   = regwen;
    hif.i_ex_is_load  = load;
    hif.i_ex_redirect = redir;
    hif.i_mem_req     = req;
    hif.i_mem_ready   = ready;
  endtask

  task automatic model_reset();
    m_stall = 0; m_flush = 0; m_run = 0; m_wait = 0; m_to = 0;
  endtask

  // One clock: compare everything at the falling edge, advance the model, land at posedge+1.
  task automatic step();
    logic [6:0] e;
    bit ms;
    @(negedge clk);
    e = ctrl_ref();
    chk("ctrl", {25'd0, ctrl_act()}, {25'd0, e});
    chk("state", {31'd0, hif.o_state}, {31'd0, m_wait});
    chk("stall_cnt", {28'd0, hif.o_stall_cnt}, m_stall);
    chk("flush_cnt", {28'd0, hif.o_flush_cnt}, m_flush);
    chk("timeout", {31'd0, hif.o_timeout}, {31'd0, m_to});
    ms = hif.i_mem_req && !hif.i_mem_ready;
    if (e[6] && m_stall < SAT) m_stall++;
    if (e[4] && m_flush < SAT) m_flush++;
    m_run = ms ? m_run + 1 : 0;
    if (m_run - 1 >= TO) m_to = 1;
    m_wait = ms;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    model_reset();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{ADD_X6_X5_X7, 5'd5, 1, 1, 0, 0, 0, C_LU};
    tbl[1]  = '{ADD_X6_X5_X7, 5'd0, 1, 1, 0, 0, 0, C_NONE};
    tbl[2]  = '{LUI_X5,       5'd5, 1, 1, 0, 0, 0, C_NONE};
    tbl[3]  = '{ADD_X6_X5_X7, 5'd7, 1, 1, 0, 0, 0, C_LU};
    tbl[4]  = '{ADD_X6_X5_X7, 5'd5, 0, 1, 0, 0, 0, C_NONE};
    tbl[5]  = '{ADD_X6_X5_X7, 5'd5, 1, 0, 0, 0, 0, C_NONE};
    tbl[6]  = '{ADDI_X6_X5,   5'd1, 1, 1, 0, 0, 0, C_NONE};
    tbl[7]  = '{ADDI_X6_X5,   5'd5, 1, 1, 0, 0, 0, C_LU};
    tbl[8]  = '{SW_X7_X5,     5'd7, 1, 1, 0, 0, 0, C_LU};
    tbl[9]  = '{JALR_X5,      5'd5, 1, 1, 0, 0, 0, C_LU};
    tbl[10] = '{ADD_X6_X5_X7, 5'd5, 1, 1, 1, 0, 0, C_RED};
    tbl[11] = '{ADD_X6_X5_X7, 5'd5, 1, 1, 1, 1, 0, C_MEM};
    tbl[12] = '{ADD_X6_X5_X7, 5'd5, 1, 1, 0, 1, 1, C_LU};
    tbl[13] = '{ADD_X6_X5_X7, 5'd5, 1, 1, 0, 0, 1, C_LU};

    set_in(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_ctrl", {25'd0, ctrl_act()}, 32'd0);
    chk("rst_state", {31'd0, hif.o_state}, 32'd0);
    chk("rst_cnt", {24'd0, hif.o_stall_cnt, hif.o_flush_cnt}, 32'd0);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i].inst, tbl[i].rd, tbl[i].regwen, tbl[i].load,
             tbl[i].redir, tbl[i].req, tbl[i].ready);
      #1;
      chk($sformatf("tbl%0d", i), {25'd0, ctrl_act()}, {25'd0, tbl[i].exp});
      step();
    end

    // Load-use bubble lasts exactly one cycle once EX moves on.
    do_reset();
    set_in(ADD_X6_X5_X7, 5'd5, 1, 1, 0, 0, 0);
    step();
    set_in(ADD_X6_X5_X7, 5'd0, 0, 0, 0, 0, 0);
    step();
    chk("lu_stall_cnt", {28'd0, hif.o_stall_cnt}, 32'd1);

    // Redirect wins over a coincident load-use.
    do_reset();
    set_in(ADD_X6_X5_X7, 5'd5, 1, 1, 1, 0, 0);
    #1;
    chk("red_pc_stall", {31'd0, hif.o_pc_stall}, 32'd0);
    step();
    chk("red_flush_cnt", {28'd0, hif.o_flush_cnt}, 32'd1);
    chk("red_stall_cnt", {28'd0, hif.o_stall_cnt}, 32'd0);

    // Three-cycle memory wait.
    do_reset();
    set_in(32'h0, 5'd0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_state", {31'd0, hif.o_state}, (i == 0) ? 32'd0 : 32'd1);
      step();
    end
    set_in(32'h0, 5'd0, 0, 0, 0, 1, 1);
    step();
    set_in(32'h0, 5'd0, 0, 0, 0, 0, 0);
    chk("mw_state_after", {31'd0, hif.o_state}, 32'd0);
    chk("mw_stall_cnt", {28'd0, hif.o_stall_cnt}, 32'd3);

    // Redirect held through a two-cycle wait flushes once, when ready rises.
    do_reset();
    set_in(32'h0, 5'd0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rw_noflush", {31'd0, hif.o_ifid_flush}, 32'd0);
      step();
    end
    set_in(32'h0, 5'd0, 0, 0, 1, 1, 1);
    #1;
    chk("rw_flush", {31'd0, hif.o_ifid_flush}, 32'd1);
    step();
    set_in(32'h0, 5'd0, 0, 0, 0, 0, 0);
    chk("rw_flush_cnt", {28'd0, hif.o_flush_cnt}, 32'd1);

    // Watchdog: counter hits TIMEOUT after TIMEOUT+1 stalled cycles.
    do_reset();
    set_in(32'h0, 5'd0, 0, 0, 0, 1, 0);
    for (int i = 0; i < TO; i++) step();
    chk("wd_not_yet", {31'd0, hif.o_timeout}, 32'd0);
    step();
    chk("wd_set", {31'd0, hif.o_timeout}, 32'd1);
    step();
    set_in(32'h0, 5'd0, 0, 0, 0, 1, 1);
    step();
    chk("wd_sticky", {31'd0, hif.o_timeout}, 32'd1);
    set_in(32'h0, 5'd0, 0, 0, 0, 1, 0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("ar_state", {31'd0, hif.o_state}, 32'd0);
    chk("ar_timeout", {31'd0, hif.o_timeout}, 32'd0);
    chk("ar_cnt", {24'd0, hif.o_stall_cnt, hif.o_flush_cnt}, 32'd0);
    chk("ar_ctrl", {25'd0, ctrl_act()}, 32'd0);
    model_reset();
    #1;
    rst = 1'b1;
    set_in(32'h0, 5'd0, 0, 0, 0, 0, 0);
    step();

    // Saturation of the stall counter.
    do_reset();
    set_in(ADD_X6_X5_X7, 5'd5, 1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall_cnt", {28'd0, hif.o_stall_cnt}, SAT);

    // Random traffic against the model, with periodic resets.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      logic [6:0] ops[8];
      ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011,
              7'b0000011, 7'b1100111, 7'b0110111, 7'b1101111};
      if (i % 60 == 0) do_reset();
      r = $urandom;
      r[6:0]   = ops[$urandom_range(0, 7)];
      r[19:15] = 5'($urandom_range(0, 7));
      r[24:20] = 5'($urandom_range(0, 7));
      set_in(r, 5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 9) < 4), ($urandom_range(0, 2) == 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
